// File: rtl/memory_tb_loader.sv
// Pixel-stream loader for the four-bank pixel memory.
// Scatters a raster-order block into the interleaved A/B/C/D layout.
module memory_tb_loader #(
  parameter int AWIDTH = 6,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic [3:0]        wr_en,
  output logic              busy,
  output logic              done
);

  localparam int PW = AWIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [PW-1:0]     p;
  logic [PW-1:0]     p_nx;
  logic              beat;
  logic [1:0]        bank;
  logic [AWIDTH-1:0] row;

  // Even/odd column and the 16-column half pick the bank.
  assign bank = {p[4], p[0]};
  assign row  = {p[PW-1:5], p[3:1]};

  // Next state, pixel counter and handshake outputs.
  always_comb begin
    state_nx = state;
    p_nx     = p;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    beat     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_LOAD;
          p_nx     = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_nx = S_IDLE;
        end else if (in_valid) begin
          beat = 1'b1;
          p_nx = p + 1'b1;
          if (p == {PW{1'b1}})
            state_nx = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      p     <= '0;
    end else begin
      state <= state_nx;
      p     <= p_nx;
    end
  end

  // Registered write port; data/address only move on a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 4'b0000;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= beat ? (4'b1000 >> bank) : 4'b0000;
      if (beat) begin
        wr_addr <= row;
        wr_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_tb_loader.sv
// Bench for memory_tb_loader: scoreboarded writes,
// bank image model and handshake/state checks.
module tb_memory_tb_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] wr_en;
  logic       busy;
  logic       done;

  memory_tb_loader #(.AWIDTH(6), .DWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] en;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_DONE} mst_t;

  wr_t        q[$];
  mst_t       m_state;
  int         m_p;
  int         n_chk;
  int         n_fail;
  int         cyc;
  int         wr_cnt;
  int         done_cnt;
  int         done_cyc;
  int         last_cyc;
  logic [3:0] wlog_en [0:511];
  logic [5:0] wlog_addr [0:511];
  logic [7:0] mem [0:3][0:63];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_en(input int p);
    logic [8:0] v;
    v = p[8:0];
    case ({v[4], v[0]})
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [5:0] exp_row(input int p);
    logic [8:0] v;
    v = p[8:0];
    return {v[7:5], v[3:1]};
  endfunction

  function automatic int bank_idx(input int p);
    logic [8:0] v;
    v = p[8:0];
    return int'({v[4], v[0]});
  endfunction

  // Negedge monitor: reference model plus scoreboard.
  initial begin
    wr_t e;
    bit  bt;
    cyc = 0;
    m_state = M_IDLE;
    m_p = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_state = M_IDLE;
        m_p = 0;
        q.delete();
      end else begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_state == M_LOAD});
        chk("busy", {31'd0, busy},
            {31'd0, m_state == M_LOAD || m_state == M_FLUSH});
        chk("done", {31'd0, done}, {31'd0, m_state == M_DONE});
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wr_en", {28'd0, wr_en}, {28'd0, e.en});
          chk("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end else begin
          chk("wr_en_idle", {28'd0, wr_en}, 32'd0);
        end
        if (wr_en != 4'b0000) begin
          if (wr_cnt < 512) begin
            wlog_en[wr_cnt] = wr_en;
            wlog_addr[wr_cnt] = wr_addr;
          end
          for (int b = 0; b < 4; b++)
            if (wr_en[3-b]) mem[b][wr_addr] = wr_data;
          wr_cnt++;
        end
        bt = (m_state == M_LOAD) && in_valid && !abort;
        if (bt) begin
          q.push_back('{en: exp_en(m_p), addr: exp_row(m_p), data: in_data});
          if (m_p == 255) last_cyc = cyc;
        end
        case (m_state)
          M_IDLE: if (start && !abort) begin
            m_state = M_LOAD;
            m_p = 0;
          end
          M_LOAD: begin
            if (abort) m_state = M_IDLE;
            else if (bt) begin
              if (m_p == 255) m_state = M_FLUSH;
              m_p++;
            end
          end
          M_FLUSH: m_state = M_DONE;
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  task automatic clear_stats();
    wr_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    last_cyc = -100;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 64; r++)
        mem[b][r] = 8'h00;
  endtask

  // Entered and left at posedge+1.
  task automatic run_block(input int duty, input int abort_at,
                           input bit poke);
    int guard;
    guard = 0;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (m_state == M_LOAD && guard < 5000) begin
      abort = (abort_at >= 0 && m_p == abort_at);
      start = poke && (m_p == 50);
      in_valid = abort || ($urandom_range(0, 99) < duty);
      in_data = in_valid ? m_p[7:0] : 'x;
      @(posedge clk); #1;
      guard++;
    end
    abort = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 'x;
    while (m_state != M_IDLE && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic readback();
    for (int p = 0; p < 256; p++)
      chk("rdback", {24'd0, mem[bank_idx(p)][exp_row(p)]}, p);
    chk("word0", {mem[0][0], mem[1][0], mem[2][0], mem[3][0]},
        32'h00011011);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    clear_stats();
    #2;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr", {14'd0, wr_en, wr_addr, wr_data}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // mid-load asynchronous reset
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    repeat (10) begin
      in_data = m_p[7:0];
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_wr", {14'd0, wr_en, wr_addr, wr_data}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // full-rate block
    clear_stats();
    run_block(100, -1, 1'b0);
    chk("wr_cnt_full", wr_cnt, 256);
    chk("done_cnt_full", done_cnt, 1);
    chk("done_lat", done_cyc - last_cyc, 2);
    chk("p0", {wlog_en[0], 22'd0, wlog_addr[0]}, {4'b1000, 28'd0});
    chk("p1", {wlog_en[1], 22'd0, wlog_addr[1]}, {4'b0100, 28'd0});
    chk("p2", {wlog_en[2], 22'd0, wlog_addr[2]}, {4'b0010 << 2, 28'd1});
    chk("p16", {wlog_en[16], 22'd0, wlog_addr[16]}, {4'b0010, 28'd0});
    chk("p17", {wlog_en[17], 22'd0, wlog_addr[17]}, {4'b0001, 28'd0});
    chk("p255", {wlog_en[255], 22'd0, wlog_addr[255]}, {4'b0001, 28'd63});
    readback();

    // throttled block
    clear_stats();
    run_block(40, -1, 1'b0);
    chk("wr_cnt_thr", wr_cnt, 256);
    chk("done_cnt_thr", done_cnt, 1);
    readback();

    // abort after 100 beats, then a fresh block
    clear_stats();
    run_block(100, 100, 1'b0);
    chk("wr_cnt_abort", wr_cnt, 100);
    chk("done_cnt_abort", done_cnt, 0);
    chk("ready_abort", {31'd0, in_ready}, 32'd0);
    clear_stats();
    run_block(100, -1, 1'b0);
    chk("restart_p0", {wlog_en[0], 22'd0, wlog_addr[0]}, {4'b1000, 28'd0});
    chk("wr_cnt_restart", wr_cnt, 256);

    // start during LOAD is ignored
    clear_stats();
    run_block(100, -1, 1'b1);
    chk("wr_cnt_poke", wr_cnt, 256);
    chk("done_cnt_poke", done_cnt, 1);
    readback();

    // start with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("startabort_busy", {31'd0, busy}, 32'd0);

    // abort on the final pixel
    clear_stats();
    run_block(100, 255, 1'b0);
    chk("wr_cnt_ab255", wr_cnt, 255);
    chk("done_cnt_ab255", done_cnt, 0);

    // back-to-back blocks
    clear_stats();
    run_block(60, -1, 1'b0);
    run_block(100, -1, 1'b0);
    chk("wr_cnt_b2b", wr_cnt, 512);
    chk("done_cnt_b2b", done_cnt, 2);
    readback();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
